// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: an 8N1 UART receiver that feeds a show-ahead byte FIFO.
// Received bytes are queued so that controller_fsm can stall, for example on
// CORDIC waits or TX back-pressure, without losing command bytes.
// Optional build macro UART_RX_PARITY_EN selects 8E1 framing and adds the
// parity_err pulse output.
module uart_rx_buffered #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_100Mhz,
  input  logic                          reset,
  input  logic                          rx_in,
  input  logic                          uld_rx_data,
  output logic [7:0]                    rx_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          overrun
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   HALF_M1 = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t          state;
  logic            rx_meta, rxs;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      idx;
  logic [7:0]      sh;
  logic            bit_tick;
  logic            push_req;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
`endif

  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, do_pop, do_push;

  // Two-stage synchronizer. It resets to the idle-high line level so that
  // leaving reset never produces a false start bit.
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  assign bit_tick = (bit_cnt == FULL_M1);

  // A byte is offered to the FIFO on the same edge that samples a good stop
  // bit. The FIFO registers it there, so the byte is visible one cycle later.
`ifdef UART_RX_PARITY_EN
  assign push_req = (state == STOP) && bit_tick && rxs && !(^{sh, par_bit});
`else
  assign push_req = (state == STOP) && bit_tick && rxs;
`endif

  // Frame FSM: mid-bit sampling, bit-timer and bit-index bookkeeping, and the
  // error pulses.
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      idx        <= '0;
      sh         <= '0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (bit_cnt == HALF_M1) begin
            bit_cnt <= '0;
            idx     <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            sh[idx] <= rxs;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            if (rxs) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              parity_err <= ^{sh, par_bit};
`endif
            end else begin
              // A framing error wins over a parity error. The FSM then waits
              // out a break so the break is not read as a stream of starts.
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          bit_cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full     = (rx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);
  assign do_pop   = uld_rx_data && !rx_empty;
  // When the FIFO is full, a pop on the same edge frees a slot for the push.
  assign do_push  = push_req && (!full || do_pop);
  assign rx_data  = mem[rd_ptr];

  // FIFO storage, pointers, occupancy and the overrun pulse.
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= push_req && full && !do_pop;
      if (do_push) begin
        mem[wr_ptr] <= sh;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Buffered UART receiver that converts the asynchronous serial `rx_in` line into bytes and queues them in a show-ahead FIFO for `controller_fsm`. It sits directly upstream of the controller's byte-load path and replaces the bare receiver inside `uart`. The FIFO decouples command-byte arrival from FSM stalls such as CORDIC waits and TX back-pressure. Its consumer interface (`rx_data`, `rx_empty`, `uld_rx_data`) is signal-compatible with the existing one.

## Interface
- `CLK_DIV`, default 868: clk_100Mhz cycles per bit (115200 baud); legal minimum 8.
- `FIFO_DEPTH`, default 16: byte entries; power of two, minimum 2.

- `clk_100Mhz`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `rx_in`  in  1  serial line; idle high; 8N1 frame, LSB first.
- `uld_rx_data`  in  1  pop request; consumes the head byte when `rx_empty`=0.
- `rx_data`  out  8  FIFO head byte; valid while `rx_empty`=0.
- `rx_empty`  out  1  FIFO empty flag.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a received byte is dropped because the FIFO is full.

## Operation
- `rx_in` passes through a 2-FF synchronizer; both FFs reset to 1. All logic below uses the synchronized value `rxs`.
- Bit counter `bit_cnt` (0..CLK_DIV-1) and bit index `idx` (0..7). Shift register `sh[7:0]`.
- Reset values: state IDLE, `rx_data`=0x00, `rx_empty`=1, `rx_count`=0, `frame_err`=0, `overrun`=0, FIFO pointers=0.
- FSM states and transitions:
  - IDLE: on `rxs`=0, go to START and clear `bit_cnt`.
  - START: when `bit_cnt` reaches CLK_DIV/2-1, sample `rxs`. If 1 (glitch), return to IDLE. If 0, go to DATA with `idx`=0 and clear `bit_cnt`.
  - DATA: every CLK_DIV cycles, sample `rxs` into `sh[idx]`. After `idx`=7, go to STOP (or PARITY; see Configuration).
  - STOP: after CLK_DIV cycles, sample. If 1, issue a push request and go to IDLE. If 0, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. This prevents a break condition from being seen as repeated start bits.
- FIFO behaviour:
  - Push when a push request is raised and the FIFO is not full.
  - If a push request arrives while full with no pop in the same cycle, pulse `overrun` and drop the new byte. Stored data is unchanged.
  - If a push and a pop occur in the same cycle while full, both succeed and no overrun is raised.
  - A pop on empty is ignored; pointers and count are unchanged.
  - If a push and a pop occur in the same cycle while empty, only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH. `rx_count` = pushes − pops and never exceeds FIFO_DEPTH.
- `rx_data` is show-ahead: it presents the head entry combinationally from the storage array. It is undefined-but-stable (last head) when empty.
- Asserting reset mid-frame or mid-FIFO aborts the frame, empties the FIFO and returns to IDLE. The partially received byte is never delivered.

## Timing
- Let T0 be the first cycle with `rxs`=0.
- Sample times relative to T0:
  - Start bit: T0 + CLK_DIV/2.
  - Data bit k: T0 + CLK_DIV/2 + (k+1)·CLK_DIV.
  - Stop bit: T0 + CLK_DIV/2 + 9·CLK_DIV.
- The push is registered at stop sample + 1. `rx_empty` falls and `rx_data` is valid in that same cycle.
- Pop: `uld_rx_data` is sampled at a clock edge. The next head byte, updated `rx_count` and `rx_empty` appear the following cycle. Holding `uld_rx_data` high pops one byte per cycle.
- `frame_err` and `overrun` are registered single-cycle pulses, issued at stop sample + 1.
- The receiver is ready for the next start edge at the stop sample + 1. Back-to-back frames with no idle gap are received correctly.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - An even-parity bit is expected between bit 7 and the stop bit (8E1), handled by an extra PARITY state sampled CLK_DIV cycles after bit 7.
  - The stop sample moves to T0 + CLK_DIV/2 + 10·CLK_DIV.
  - A port `parity_err` (out, 1, reset 0) pulses at stop sample + 1 on mismatch, and the byte is discarded.
  - A frame error takes precedence; only `frame_err` pulses.
- `UART_RX_PARITY_EN` undefined:
  - 8N1 framing, no PARITY state, no `parity_err` port.

## Test plan
- Bench at CLK_DIV=16. Send 0xA5 8N1 → `rx_empty` falls at T0+8+144+1, `rx_data`=0xA5, `rx_count`=1. Pulse `uld_rx_data` → `rx_empty`=1.
- Send 0x12, 0x34, 0x56 back-to-back with no idle, no pops → `rx_count`=3. Pop three times → outputs 0x12, 0x34, 0x56 in order.
- FIFO_DEPTH=4: send 5 bytes with no pops → the 5th raises `overrun` for one cycle, `rx_count`=4, head=first byte. Then send a byte while popping in its push cycle → no overrun, `rx_count` stays 4.
- Drive a 4-cycle low glitch on `rx_in` → no push, state back to IDLE, `rx_empty`=1.
- Send 0x3C with stop bit low, then hold the line low for 40 cycles, then send 0x81 → one `frame_err` pulse, no extra bytes, only 0x81 queued.
- Assert reset mid-frame (after bit 3) with 2 bytes queued → `rx_empty`=1, `rx_count`=0, no pulses. The next clean frame 0x7E is received correctly.
